// File: rtl/rptr_empty.sv
// Read-side pointer and empty-flag logic of the async FIFO: binary/Gray read pointer, empty, level, underflow.
// Optional almost-empty output built only when RPTR_ALMOST_EMPTY_EN is defined.
module rptr_empty #(
  parameter int ADDR      = 3,
  parameter int RAE_LEVEL = 1
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            rinc,
  input  logic [ADDR:0]   rq2_wptr,
  input  logic            runderflow_clr,
  output logic [ADDR-1:0] raddr,
  output logic [ADDR:0]   rptr,
  output logic            rempty,
  output logic [ADDR:0]   rlevel,
`ifdef RPTR_ALMOST_EMPTY_EN
  output logic            ralmost_empty,
`endif
  output logic            runderflow
);

  logic            ren;
  logic [ADDR:0]   rbin_q, rbin_d;
  logic [ADDR:0]   rptr_q, rptr_d;
  logic [ADDR:0]   rlevel_q, rlevel_d;
  logic [ADDR:0]   wbin;
  logic            rempty_q, rempty_d;
  logic            runderflow_q, runderflow_d;

  always_comb begin
    ren          = rinc & ~rempty_q;
    rbin_d       = rbin_q + (ADDR+1)'(ren);
    rptr_d       = (rbin_d >> 1) ^ rbin_d;
    // Full-width Gray compare keeps empty pessimistic against a lagging write pointer
    rempty_d     = (rptr_d == rq2_wptr);
    wbin         = '0;
    wbin[ADDR]   = rq2_wptr[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
    rlevel_d     = wbin - rbin_d;
    // A new underflow outranks a simultaneous clear
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~runderflow_clr);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
    end
  end

`ifdef RPTR_ALMOST_EMPTY_EN
  logic ralmost_empty_q, ralmost_empty_d;

  always_comb begin
    ralmost_empty_d = (rlevel_d <= (ADDR+1)'(RAE_LEVEL));
  end

  always_ff @(posedge rclk) begin
    if (rrst) ralmost_empty_q <= 1'b1;
    else      ralmost_empty_q <= ralmost_empty_d;
  end

  assign ralmost_empty = ralmost_empty_q;
`endif

  assign raddr      = rbin_q[ADDR-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty (ADDR=3): directed scenarios then random traffic against a count-based reference model.
module tb_rptr_empty;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rinc = 1'b0;
  logic [3:0] rq2_wptr = 4'b0000;
  logic       runderflow_clr = 1'b0;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [3:0] rlevel;
  logic       runderflow;
`ifdef RPTR_ALMOST_EMPTY_EN
  logic       ralmost_empty;
`endif

  rptr_empty #(.ADDR(3), .RAE_LEVEL(2)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .runderflow_clr(runderflow_clr), .raddr(raddr), .rptr(rptr),
    .rempty(rempty), .rlevel(rlevel),
`ifdef RPTR_ALMOST_EMPTY_EN
    .ralmost_empty(ralmost_empty),
`endif
    .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int fails = 0;

  // Reference model: plain counts of entries read and written
  int m_rbin  = 0;
  int m_wbin  = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  function automatic logic [3:0] to_gray(int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wptr(int wb);
    m_wbin   = wb % 16;
    rq2_wptr = to_gray(m_wbin);
  endtask

  // One rising edge: advance the model from the inputs present, then compare all outputs
  task automatic step();
    int nb;
    @(posedge rclk);
    if (rrst) begin
      m_rbin = 0; m_empty = 1'b1; m_level = 0; m_uf = 1'b0;
    end else begin
      nb      = (m_rbin + ((rinc && !m_empty) ? 1 : 0)) % 16;
      m_uf    = (rinc && m_empty) || (m_uf && !runderflow_clr);
      m_level = (m_wbin - nb + 16) % 16;
      m_empty = (m_level == 0);
      m_rbin  = nb;
    end
    #1;
    chk("raddr",      32'(raddr),      32'(m_rbin % 8));
    chk("rptr",       32'(rptr),       32'(to_gray(m_rbin)));
    chk("rempty",     32'(rempty),     32'(m_empty));
    chk("rlevel",     32'(rlevel),     32'(m_level));
    chk("runderflow", 32'(runderflow), 32'(m_uf));
`ifdef RPTR_ALMOST_EMPTY_EN
    chk("ralmost_empty", 32'(ralmost_empty), 32'(m_level <= 2));
`endif
  endtask

  initial begin
    // Reset held two cycles with rinc high
    rrst = 1'b1; rinc = 1'b1; set_wptr(0);
    step(); step();
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_rptr",   32'(rptr),   32'd0);
    chk("rst_rlevel", 32'(rlevel), 32'd0);

    // Fill: write pointer at binary 3
    rrst = 1'b0; rinc = 1'b0; set_wptr(3);
    step();
    chk("fill_rempty", 32'(rempty), 32'd0);
    chk("fill_rlevel", 32'(rlevel), 32'd3);
`ifdef RPTR_ALMOST_EMPTY_EN
    chk("fill_ae", 32'(ralmost_empty), 32'd0);
`endif

    // Drain three entries
    rinc = 1'b1;
    step();
    chk("drain1_raddr", 32'(raddr), 32'd1);
    chk("drain1_rptr",  32'(rptr),  32'b0001);
`ifdef RPTR_ALMOST_EMPTY_EN
    chk("drain1_ae", 32'(ralmost_empty), 32'd1);
`endif
    step();
    chk("drain2_rptr",  32'(rptr),  32'b0011);
    step();
    chk("drain3_raddr", 32'(raddr), 32'd3);
    chk("drain3_rptr",  32'(rptr),  32'b0010);
    chk("drain3_empty", 32'(rempty), 32'd1);

    // Wrap: advance both pointers to binary 8
    rinc = 1'b0; set_wptr(8);
    step();
    rinc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("wrap_raddr", 32'(raddr), 32'd0);
    chk("wrap_rptr",  32'(rptr),  32'b1100);
    chk("wrap_empty", 32'(rempty), 32'd1);
    rinc = 1'b0; set_wptr(16);
    step();
    chk("wrap_full_empty", 32'(rempty), 32'd0);
    chk("wrap_full_level", 32'(rlevel), 32'd8);
    rinc = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("wrap_back_rptr", 32'(rptr), 32'd0);

    // Underflow: set, hold, clear, then set and clear together
    step();
    chk("uf_set",  32'(runderflow), 32'd1);
    chk("uf_rptr", 32'(rptr),       32'd0);
    rinc = 1'b0;
    step();
    chk("uf_hold", 32'(runderflow), 32'd1);
    runderflow_clr = 1'b1;
    step();
    chk("uf_clr", 32'(runderflow), 32'd0);
    rinc = 1'b1;
    step();
    chk("uf_set_wins", 32'(runderflow), 32'd1);
    rinc = 1'b0; runderflow_clr = 1'b0;

    // Mid-operation reset with level 5 and a read pending
    set_wptr(5);
    step();
    chk("mid_level", 32'(rlevel), 32'd5);
    rinc = 1'b1; rrst = 1'b1;
    step();
    chk("mid_rst_empty", 32'(rempty), 32'd1);
    chk("mid_rst_level", 32'(rlevel), 32'd0);
    chk("mid_rst_raddr", 32'(raddr),  32'd0);
    rrst = 1'b0; rinc = 1'b0; set_wptr(0);
    step();

    // Random traffic with a legal writer (never more than 8 ahead of the reader)
    for (int i = 0; i < 600; i++) begin
      rinc           = ($urandom_range(0, 99) < 55);
      runderflow_clr = ($urandom_range(0, 9) == 0);
      rrst           = ($urandom_range(0, 199) == 0);
      if ((($urandom_range(0, 1) == 1)) && (((m_wbin - m_rbin + 16) % 16) < 8))
        set_wptr(m_wbin + 1);
      if (rrst) set_wptr(0);
      step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
